// File: rtl/sp_ram_bank.sv
// rtl/sp_ram_bank.sv - parametrised single-port synchronous RAM with byte enables,
// selectable read-during-write behaviour, optional output register and zero-fill sweep.
module sp_ram_bank #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 6,
  parameter int DEPTH          = 2**ADDR_W,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data,
  input  logic                clr,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                busy
);

  localparam int              NB      = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_next;
  logic [ADDR_W:0]     cnt, cnt_next;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range, acc, acc_wr;
  logic [DATA_W-1:0]   old_word, merged;
  logic                res_load, res_valid;
  logic [DATA_W-1:0]   res_data;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;

  assign busy     = (state == CLEAR);
  assign in_range = ({1'b0, addr} < DEPTH_C);
  // A clr pulse takes priority over any access presented in the same cycle.
  assign acc      = !busy && en && !clr;
  assign acc_wr   = acc && we && in_range;
  assign old_word = in_range ? mem[addr] : '0;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clr) state_next = CLEAR;
      end
      CLEAR: begin
        if (cnt == LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + (ADDR_W+1)'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result of this cycle's access; res_load=0 leaves the read register holding.
  always_comb begin
    res_load  = 1'b0;
    res_valid = 1'b0;
    res_data  = old_word;
    if (acc) begin
      if (!we || RDW_MODE == 0) begin
        res_load  = 1'b1;
        res_valid = 1'b1;
      end else if (RDW_MODE == 1) begin
        res_load  = 1'b1;
        res_valid = 1'b1;
        res_data  = in_range ? merged : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      rd_valid <= res_valid;
      if (res_load) rd_data <= res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt[ADDR_W-1:0]] <= '0;
    end else if (acc_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= data[8*i +: 8];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] q_r;
      logic              v_r;
      // A result still in flight when a sweep starts is not flagged valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_r <= '0;
          v_r <= 1'b0;
        end else begin
          q_r <= rd_data;
          v_r <= rd_valid && (state_next == IDLE);
        end
      end
      assign q       = q_r;
      assign q_valid = v_r;
    end else begin : g_noreg
      assign q       = rd_data;
      assign q_valid = rd_valid;
    end
  endgenerate

endmodule
